// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width and the parity helper
// used by both the RX and TX sides.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Parity bit that makes the frame even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period tick counter: counts 0..BIT_COUNTS-1 and wraps, flags mid-bit and
// end-of-bit positions for the receive FSM.
module uart_bit_timer #(
  parameter int BIT_COUNTS = 5
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic at_half,
  output logic at_end
);

  localparam int CNT_W = (BIT_COUNTS > 1) ? $clog2(BIT_COUNTS) : 1;
  localparam int HALF  = BIT_COUNTS / 2;

  logic [CNT_W-1:0] tick;

  assign at_half = (tick == CNT_W'(HALF));
  assign at_end  = (tick == CNT_W'(BIT_COUNTS - 1));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tick <= '0;
    end else if (clr) begin
      tick <= '0;
    end else if (en) begin
      tick <= at_end ? '0 : tick + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: synchronizes the line, samples one frame at
// mid-bit, and hands each byte to the consumer through a 1-deep valid/ready register.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int BIT_COUNTS = 5,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rx_line,
  input  logic              rx_ready,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  rx_state_t         state;
  logic              sync1, rxs, rxs_d;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              perr;
  logic              at_half, at_end;
  logic              timer_clr;
  logic              deliver, blocked, accept;

  // Synchronizer resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_line;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // Timer idles at zero and restarts when START hands over to DATA; every later
  // state boundary coincides with its natural wrap.
  assign timer_clr = (state == IDLE) || ((state == START) && at_half);

  uart_bit_timer #(
    .BIT_COUNTS(BIT_COUNTS)
  ) u_bit_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (timer_clr),
    .en     (1'b1),
    .at_half(at_half),
    .at_end (at_end)
  );

  assign deliver = (state == STOP) && at_end;
  assign blocked = rx_valid && !rx_ready;
  assign accept  = deliver && !blocked;

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values of state, shreg and rx_valid.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Sticky flags: a set in the same cycle as clr_err wins.
      parity_err <= (accept && perr)        || (parity_err && !clr_err);
      frame_err  <= (accept && !rxs)        || (frame_err  && !clr_err);
      overrun    <= (deliver && blocked)    || (overrun    && !clr_err);

      if (accept) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (rxs_d && !rxs) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (at_half) begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
              perr    <= 1'b0;
            end
          end
        end
        DATA: begin
          if (at_end) begin
            shreg   <= {rxs, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY_EN ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (at_end) begin
            perr  <= (parity_bit(shreg, PARITY_ODD) != rxs);
            state <= STOP;
          end
        end
        STOP: begin
          if (at_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: even parity, 5 clocks per bit, frames
// built bit by bit with hand-computed parity and expected bytes.
module tb_uart_rx_frame_ctrl;

  localparam int BC      = 5;
  localparam int HALF    = BC / 2;
  localparam int PEN     = 1;
  localparam int LATENCY = (HALF + 1) + (8 + PEN + 1) * BC;   // busy rise -> rx_valid rise

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rx_line = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;

  uart_rx_frame_ctrl #(
    .BIT_COUNTS(BC),
    .PARITY_EN (1'b1),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_line   (rx_line),
    .rx_ready  (rx_ready),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: consumed bytes, valid-high cycles, edge timestamps.
  logic [7:0] got_q[$];
  int   cyc = 0, valid_cycles = 0, busy_rises = 0, busy_rise_cyc = 0, valid_rise_cyc = 0;
  logic prev_busy = 1'b0, prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (busy && !prev_busy) begin
      busy_rises++;
      busy_rise_cyc = cyc;
    end
    if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_busy  = busy;
    prev_valid = rx_valid;
  end

  // Inputs change and outputs are read 2 ns after each rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    step(BC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int idle);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    rx_line = 1'b1;
    step(idle);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    b = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
    check(tag, {24'd0, b}, {24'd0, exp});
  endtask

  task automatic check_flags(input string tag, input logic p, input logic f, input logic o);
    check({tag, "_perr"}, {31'd0, parity_err}, {31'd0, p});
    check({tag, "_ferr"}, {31'd0, frame_err},  {31'd0, f});
    check({tag, "_ovr"},  {31'd0, overrun},    {31'd0, o});
  endtask

  initial begin
    int n;
    int br;

    // Reset state
    step(3);
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_data",  {24'd0, rx_data},  0);
    check("rst_busy",  {31'd0, busy},     0);
    check_flags("rst", 0, 0, 0);
    n_rst    = 1'b1;
    rx_ready = 1'b1;
    step(4);

    // 1: clean frames, latency and single-cycle valid pulse
    valid_cycles = 0;
    send_frame(8'hA5, 1'b0, 1'b1, 4);
    check("t1_count", got_q.size(), 1);
    expect_byte("t1_data", 8'hA5);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_latency", valid_rise_cyc - busy_rise_cyc, LATENCY);
    check("t1_busy", {31'd0, busy}, 0);
    check_flags("t1", 0, 0, 0);
    send_frame(8'h07, 1'b1, 1'b1, 4);
    expect_byte("t1_data07", 8'h07);
    check("t1_perr07", {31'd0, parity_err}, 0);

    // 2: wrong parity, sticky until clr_err
    send_frame(8'h01, 1'b0, 1'b1, 4);
    expect_byte("t2_data", 8'h01);
    check("t2_perr", {31'd0, parity_err}, 1);
    step(10);
    check("t2_perr_sticky", {31'd0, parity_err}, 1);
    pulse_clr();
    check("t2_perr_clr", {31'd0, parity_err}, 0);

    // 3: framing error, then a clean frame
    send_frame(8'h3C, 1'b0, 1'b0, 4);
    expect_byte("t3_data", 8'h3C);
    check_flags("t3", 0, 1, 0);
    send_frame(8'h55, 1'b0, 1'b1, 4);
    expect_byte("t3_data55", 8'h55);
    check("t3_ferr_sticky", {31'd0, frame_err}, 1);
    pulse_clr();
    check("t3_ferr_clr", {31'd0, frame_err}, 0);

    // 4: overrun, then consume and deliver in the same cycle
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 4);
    check("t4_valid", {31'd0, rx_valid}, 1);
    check("t4_data11", {24'd0, rx_data}, 32'h11);
    send_frame(8'h22, 1'b0, 1'b1, 4);
    check("t4_data_kept", {24'd0, rx_data}, 32'h11);
    check_flags("t4", 0, 0, 1);
    pulse_clr();
    check("t4_ovr_clr", {31'd0, overrun}, 0);
    got_q.delete();
    fork
      send_frame(8'h33, 1'b0, 1'b1, 4);
      begin
        n = 0;
        while (!busy && n < 200) begin
          step(1);
          n++;
        end
        check("t4_busy_seen", {31'd0, busy}, 1);
        step(LATENCY - 1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        check("t4_swap_data", {24'd0, rx_data}, 32'h33);
        check("t4_swap_valid", {31'd0, rx_valid}, 1);
        check("t4_swap_ovr", {31'd0, overrun}, 0);
      end
    join
    rx_ready = 1'b1;
    step(2);
    check("t4_count", got_q.size(), 2);
    expect_byte("t4_first", 8'h11);
    expect_byte("t4_second", 8'h33);

    // 5: one-cycle glitch enters START and falls back without a byte
    got_q.delete();
    br = busy_rises;
    rx_line = 1'b0;
    step(1);
    rx_line = 1'b1;
    step(20);
    check("t5_start_entered", busy_rises, br + 1);
    check("t5_no_byte", got_q.size(), 0);
    check("t5_busy", {31'd0, busy}, 0);
    check_flags("t5", 0, 0, 0);
    send_frame(8'h7E, 1'b0, 1'b1, 4);
    expect_byte("t5_data", 8'h7E);

    // 6: reset mid-DATA clears everything
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1, 4);
    check("t6_pre_perr", {31'd0, parity_err}, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t6_pre_busy", {31'd0, busy}, 1);
    rx_line = 1'b1;
    n_rst   = 1'b0;
    step(1);
    n_rst   = 1'b1;
    check("t6_rst_valid", {31'd0, rx_valid}, 0);
    check("t6_rst_data",  {24'd0, rx_data},  0);
    check("t6_rst_busy",  {31'd0, busy},     0);
    check_flags("t6_rst", 0, 0, 0);
    step(2 * BC);
    rx_ready = 1'b1;
    got_q.delete();
    send_frame(8'hC3, 1'b0, 1'b1, 4);
    expect_byte("t6_dataC3", 8'hC3);
    send_frame(8'h0F, 1'b0, 1'b1, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 4);
    check("t6_b2b_count", got_q.size(), 2);
    expect_byte("t6_b2b_first", 8'h0F);
    expect_byte("t6_b2b_second", 8'hF0);
    check_flags("t6_end", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
